// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : constants and state encoding shared across the multiplier datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int PP_W   = 130;
    localparam int NUM_PP = 33;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_RES  = 2'd1,
        S_DONE = 2'd2
    } acc_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa3.sv
// ============================================================================
// csa3 : combinational 3:2 compressor producing sum and left-shifted carry
// Rev 1.0
// ============================================================================
`default_nettype none

module csa3
    import mul_pkg::*;
#(
    parameter int W = 130
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign carry_o[0] = 1'b0;

    // Carry out of bit i lands in bit i+1; the carry out of the MSB is dropped.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_i[i];
        if (i > 0) begin : g_carry
            assign carry_o[i] = maj3(a_i[i-1], b_i[i-1], c_i[i-1]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pp_accumulator.sv
// ============================================================================
// pp_accumulator : carry-save accumulation of Booth partial products, one
//                  final carry-propagate add, result on a valid/ready port
// Rev 1.0
// ============================================================================
`default_nettype none

module pp_accumulator #(
    parameter int PP_W   = mul_pkg::PP_W,
    parameter int NUM_PP = mul_pkg::NUM_PP,
    parameter int CNT_W  = mul_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [PP_W-1:0]  pp_data,
    input  logic             pp_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PP_W-1:0]  res_data,
    output logic [CNT_W-1:0] res_count
);
    import mul_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NUM_PP - 1);

    acc_state_e       state_q;
    logic [PP_W-1:0]  s_q;
    logic [PP_W-1:0]  c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             res_valid_q;
    logic [PP_W-1:0]  res_data_q;
    logic [CNT_W-1:0] res_count_q;

    logic [PP_W-1:0]  s_d;
    logic [PP_W-1:0]  c_d;
    logic [CNT_W-1:0] cnt_d;
    logic             w_term;

    csa3 #(
        .W (PP_W)
    ) u_csa3 (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (pp_data),
        .sum_o   (s_d),
        .carry_o (c_d)
    );

    assign cnt_d  = cnt_q + 1'b1;
    // Stop on an explicit last beat or when the beat budget is exhausted.
    assign w_term = pp_last || (cnt_q == C_LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else if (flush) begin
            state_q     <= S_ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (pp_valid) begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        cnt_q <= cnt_d;
                        if (w_term) begin
                            state_q <= S_RES;
                        end
                    end
                end
                S_RES: begin
                    res_data_q  <= s_q + c_q;
                    res_count_q <= cnt_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        s_q         <= '0;
                        c_q         <= '0;
                        cnt_q       <= '0;
                        res_valid_q <= 1'b0;
                        state_q     <= S_ACC;
                    end
                end
                default: begin
                    state_q <= S_ACC;
                end
            endcase
        end
    end

    assign pp_ready  = (state_q == S_ACC);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;

endmodule

`default_nettype wire
